overture_branch_seq: RTL and testbench
======================================

Name: overture_branch_seq

Overview:
- Program-counter sequencer for the OVERTURE datapath; consumes the condition-code encoding that the condition evaluator decodes.
- Issues instruction fetches to program memory and waits for each response.
- Classifies each returned instruction byte: condition-class bytes are evaluated against the condition register and load the jump target when the condition holds; all other bytes advance the PC by one.
- Sits between program memory and the decode/ALU stage; also provides a retired-instruction counter and a fetch-timeout error.

Parameters:
- RESET_PC, 8'd0, PC value loaded on reset.
- TIMEOUT, 16, maximum WAIT cycles allowed per fetch before error; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- halt  in  1  when high, no new fetch is issued.
- instr_valid  in  1  program-memory response strobe; qualifies instr.
- instr  in  8  returned instruction byte.
- reg_target  in  8  jump target (REG0 value).
- reg_cond  in  8  condition operand (REG3 value), two's complement.
- fetch_req  out  1  fetch request, one cycle per fetch.
- fetch_addr  out  8  fetch address; always equals pc.
- pc  out  8  current program counter.
- taken  out  1  registered one-cycle pulse: a condition-class instruction jumped.
- retired  out  16  count of accepted instructions.
- err  out  1  sticky fetch-timeout flag.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, taken=0, retired=0, err=0, state=FETCH, wait_cnt=0.
- fetch_req is combinational: (state==FETCH && !halt). It is therefore first high in the first cycle after rst deasserts, if halt is low.
- FETCH state:
  - If halt is low: fetch_req=1 with fetch_addr=pc; next state is WAIT with wait_cnt=0.
  - If halt is high: remain in FETCH with fetch_req=0.
- WAIT state:
  - instr_valid is ignored outside WAIT, including the cycle in which fetch_req is high. The minimum response latency is 1 cycle.
  - On instr_valid=1: accept instr, update pc, increment retired (16-bit, wraps at 0xFFFF to 0), go to FETCH.
  - halt has no effect in WAIT; the outstanding fetch always completes.
  - On instr_valid=0: wait_cnt increments. If wait_cnt==TIMEOUT-1, go to ERROR instead.
  - A valid response in the TIMEOUT-th WAIT cycle is accepted; a response after that is not.
- ERROR state:
  - err=1, fetch_req=0, pc frozen, instr_valid ignored.
  - Exit only through rst.
- Instruction classification on accept:
  - instr[7:6]==2'b11 is condition class; code = instr[2:0].
  - Z = (reg_cond==0); N = reg_cond[7].
  - Code 0: never. Code 1: Z. Code 2: N. Code 3: N|Z. Code 4: always. Code 5: !Z. Code 6: !N. Code 7: !N & !Z.
  - Condition true: pc <= reg_target and taken=1 in the next cycle. Condition false: pc <= pc+1.
  - Any other class: pc <= pc+1, taken=0.
- PC arithmetic: pc+1 is modulo 256, so 0xFF wraps to 0x00. A jump target may equal pc (self-loop is legal).
- Latency: response accepted in cycle N → new pc visible, and fetch_req high for the new address, in cycle N+1 (halt low). Steady-state throughput is one instruction per 2 cycles with a 1-cycle memory.
- taken is high for exactly one cycle per taken jump and is 0 in all other cycles.
- reg_target and reg_cond are sampled only in the accept cycle.
- Reset mid-operation: rst in any state (including WAIT with a response present, or ERROR) wins over every other event. Any response in the reset cycle is discarded.

Test Plan:
- Reset with RESET_PC=0x10, halt=0: fetch_req=1 and fetch_addr=0x10 in the first post-reset cycle. Respond instr=0x00 one cycle later → pc=0x11, retired=1, taken=0.
- reg_cond=0x80, reg_target=0x40, instr=0xC2 (code 2): pc=0x40 and taken pulses once. Repeat with instr=0xC7: pc=0x41, taken=0.
- Sweep codes 0–7 with reg_cond ∈ {0x00, 0x01, 0xFF}; taken must match the truth table exactly, 24 cases.
- pc=0xFF, non-branch instruction → pc=0x00. Also hold retired at 0xFFFF and accept one instruction → retired=0x0000.
- TIMEOUT=4: withhold instr_valid for 3 WAIT cycles, assert in the 4th → accepted, err=0. Next fetch: withhold 4 cycles → err=1, fetch_req stays 0, and a later instr_valid is ignored until rst.
- Assert halt while in WAIT: the response is still accepted, then fetch_req stays 0 until halt falls, then the fetch resumes at the updated pc. Assert rst while a response is present → pc=RESET_PC and retired unchanged at 0.

Source files
------------

// File: rtl/overture_branch_seq.sv
// overture_branch_seq: program-counter sequencer for the OVERTURE datapath.
// Issues one fetch at a time, waits for the program-memory response, and
// either advances the PC or loads the jump target for condition-class bytes
// whose condition holds. Also counts retired instructions and flags fetch
// timeouts (sticky until reset).
module overture_branch_seq #(
  parameter logic [7:0]  RESET_PC = 8'd0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        instr_valid,
  input  logic [7:0]  instr,
  input  logic [7:0]  reg_target,
  input  logic [7:0]  reg_cond,
  output logic        fetch_req,
  output logic [7:0]  fetch_addr,
  output logic [7:0]  pc,
  output logic        taken,
  output logic [15:0] retired,
  output logic        err
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  // Last WAIT cycle (counted from 0) in which a response is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       z_flag, n_flag, is_cond, cond_true;
  logic       unused_instr_bits;

  // Bits 5:3 carry no meaning for the sequencer.
  assign unused_instr_bits = ^instr[5:3];

  assign fetch_req  = (state == S_FETCH) && !halt;
  assign fetch_addr = pc;

  // Decode the condition code against the condition register flags.
  always_comb begin
    z_flag    = (reg_cond == 8'd0);
    n_flag    = reg_cond[7];
    is_cond   = (instr[7:6] == 2'b11);
    cond_true = 1'b0;
    case (instr[2:0])
      3'd0: cond_true = 1'b0;
      3'd1: cond_true = z_flag;
      3'd2: cond_true = n_flag;
      3'd3: cond_true = n_flag | z_flag;
      3'd4: cond_true = 1'b1;
      3'd5: cond_true = !z_flag;
      3'd6: cond_true = !n_flag;
      3'd7: cond_true = !n_flag & !z_flag;
      default: cond_true = 1'b0;
    endcase
  end

  // Sequencer state, PC update, retire count and timeout tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      pc       <= RESET_PC;
      taken    <= 1'b0;
      retired  <= 16'd0;
      err      <= 1'b0;
    end else begin
      taken <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!halt) begin
            state    <= S_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        S_WAIT: begin
          if (instr_valid) begin
            state   <= S_FETCH;
            retired <= retired + 16'd1;
            if (is_cond && cond_true) begin
              pc    <= reg_target;
              taken <= 1'b1;
            end else begin
              pc <= pc + 8'd1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERROR;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_ERROR: begin
          err <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park in the error state.
          state <= S_ERROR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_overture_branch_seq.sv
// Self-checking bench for overture_branch_seq: directed sequences, a
// condition-code truth table, and randomized per-cycle stimulus against a
// transaction-level reference model.
module tb_overture_branch_seq;

  localparam logic [7:0] RPC = 8'h10;
  localparam int         TMO = 4;

  logic        clk = 1'b0;
  logic        rst, halt, instr_valid;
  logic [7:0]  instr, reg_target, reg_cond;
  logic        fetch_req, taken, err;
  logic [7:0]  fetch_addr, pc;
  logic [15:0] retired;

  overture_branch_seq #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .halt(halt), .instr_valid(instr_valid),
    .instr(instr), .reg_target(reg_target), .reg_cond(reg_cond),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .pc(pc),
    .taken(taken), .retired(retired), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an outstanding-fetch flag plus a count of empty waits.
  logic [7:0]  m_pc;
  logic [15:0] m_ret;
  bit          m_err, m_taken, m_out, m_ok;
  int          m_waited;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] cond;
    bit         exp_taken;
  } vec_t;
  vec_t tbl[24];

  function automatic bit cond_holds(input logic [2:0] code, input logic [7:0] v);
    int s;
    s = int'($signed(v));
    case (code)
      3'd0: return 1'b0;
      3'd1: return s == 0;
      3'd2: return s < 0;
      3'd3: return s <= 0;
      3'd4: return 1'b1;
      3'd5: return s != 0;
      3'd6: return s >= 0;
      default: return s > 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("m_fetch_req", int'(fetch_req), int'(!m_out && !m_err && !halt));
    chk("m_fetch_addr", int'(fetch_addr), int'(m_pc));
    chk("m_pc", int'(pc), int'(m_pc));
    chk("m_taken", int'(taken), int'(m_taken));
    chk("m_retired", int'(retired), int'(m_ret));
    chk("m_err", int'(err), int'(m_err));
  endtask

  task automatic model_clk();
    if (rst) begin
      m_pc = RPC; m_ret = 16'd0; m_err = 0; m_taken = 0; m_out = 0; m_waited = 0;
      m_ok = 1;
    end else if (m_err) begin
      m_taken = 0;
    end else if (!m_out) begin
      m_taken = 0;
      if (!halt) begin m_out = 1; m_waited = 0; end
    end else if (instr_valid) begin
      m_taken = (instr[7:6] == 2'b11) && cond_holds(instr[2:0], reg_cond);
      m_pc    = m_taken ? reg_target : 8'(m_pc + 8'd1);
      m_ret   = m_ret + 16'd1;
      m_out   = 0;
    end else begin
      m_taken = 0;
      m_waited++;
      if (m_waited == TMO) m_err = 1;
    end
  endtask

  // One clock: compare against the model, let the edge happen, update model.
  task automatic cyc();
    #1;
    if (m_ok) check_model();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic do_instr(input logic [7:0] ins, input logic [7:0] tgt,
                          input logic [7:0] cnd, input int lat);
    halt = 0; instr_valid = 0;
    cyc();
    repeat (lat) cyc();
    instr_valid = 1; instr = ins; reg_target = tgt; reg_cond = cnd;
    cyc();
    instr_valid = 0;
  endtask

  initial begin
    logic [7:0] masks [3];
    logic [7:0] conds [3];
    logic [7:0] saved_pc;
    logic [15:0] saved_ret;
    m_ok = 0; m_pc = 0; m_ret = 0; m_err = 0; m_taken = 0; m_out = 0; m_waited = 0;
    rst = 1; halt = 0; instr_valid = 0; instr = 0; reg_target = 0; reg_cond = 0;

    // Truth table: bit i of the mask is the expected outcome of code i.
    conds[0] = 8'h00; masks[0] = 8'h5A;
    conds[1] = 8'h01; masks[1] = 8'hF0;
    conds[2] = 8'hFF; masks[2] = 8'h3C;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 8; k++) begin
        tbl[c*8+k].instr     = 8'hC0 | 8'(k);
        tbl[c*8+k].cond      = conds[c];
        tbl[c*8+k].exp_taken = masks[c][k];
      end
    end

    // Reset state and first fetch.
    cyc(); cyc();
    chk("rst_pc", int'(pc), 'h10);
    chk("rst_retired", int'(retired), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_taken", int'(taken), 0);
    rst = 0; halt = 0;
    #1;
    chk("first_fetch_req", int'(fetch_req), 1);
    chk("first_fetch_addr", int'(fetch_addr), 'h10);
    cyc();
    instr_valid = 1; instr = 8'h00;
    cyc();
    instr_valid = 0;
    chk("first_pc", int'(pc), 'h11);
    chk("first_retired", int'(retired), 1);
    chk("first_taken", int'(taken), 0);

    // Taken and not-taken branches on a negative operand.
    do_instr(8'hC2, 8'h40, 8'h80, 0);
    chk("br_c2_pc", int'(pc), 'h40);
    chk("br_c2_taken", int'(taken), 1);
    do_instr(8'hC7, 8'h40, 8'h80, 0);
    chk("br_c7_pc", int'(pc), 'h41);
    chk("br_c7_taken", int'(taken), 0);

    // Condition-code sweep.
    for (int k = 0; k < 24; k++) begin
      do_instr(tbl[k].instr, 8'h20 + 8'(k), tbl[k].cond, k % 3);
      chk($sformatf("sweep_taken_%0d", k), int'(taken), int'(tbl[k].exp_taken));
    end

    // PC wrap and retired wrap.
    do_instr(8'hC4, 8'hFF, 8'h00, 0);
    chk("wrap_pre_pc", int'(pc), 'hFF);
    force dut.retired = 16'hFFFF;
    #1;
    release dut.retired;
    m_ret = 16'hFFFF;
    do_instr(8'h00, 8'h00, 8'h00, 1);
    chk("wrap_pc", int'(pc), 'h00);
    chk("wrap_retired", int'(retired), 0);

    // Response in the last permitted wait cycle is accepted.
    saved_ret = m_ret;
    do_instr(8'h05, 8'h00, 8'h00, TMO - 1);
    chk("tmo_edge_err", int'(err), 0);
    chk("tmo_edge_retired", int'(retired), int'(saved_ret + 16'd1));
    // One cycle longer is a timeout; later responses are ignored.
    saved_pc = m_pc; saved_ret = m_ret;
    halt = 0; instr_valid = 0;
    cyc();
    repeat (TMO) cyc();
    chk("tmo_err", int'(err), 1);
    instr_valid = 1; instr = 8'hC4; reg_target = 8'h77;
    repeat (3) begin
      #1;
      chk("tmo_fetch_req", int'(fetch_req), 0);
      cyc();
    end
    chk("tmo_pc_frozen", int'(pc), int'(saved_pc));
    chk("tmo_retired_frozen", int'(retired), int'(saved_ret));
    chk("tmo_err_sticky", int'(err), 1);
    instr_valid = 0; rst = 1;
    cyc();
    rst = 0;
    chk("tmo_clear_err", int'(err), 0);

    // halt raised while waiting: response still completes, then stall.
    halt = 0; instr_valid = 0;
    cyc();
    halt = 1; instr_valid = 1; instr = 8'h00;
    cyc();
    instr_valid = 0;
    chk("halt_accept_pc", int'(pc), 'h11);
    chk("halt_accept_ret", int'(retired), 1);
    repeat (3) begin
      #1;
      chk("halt_no_fetch", int'(fetch_req), 0);
      cyc();
    end
    halt = 0;
    #1;
    chk("halt_resume_req", int'(fetch_req), 1);
    chk("halt_resume_addr", int'(fetch_addr), 'h11);
    cyc();
    instr_valid = 1; instr = 8'h00;
    cyc();
    instr_valid = 0;
    chk("halt_after_pc", int'(pc), 'h12);

    // Reset wins over a response present in the same cycle.
    cyc();
    rst = 1; instr_valid = 1; instr = 8'hC4; reg_target = 8'h99; reg_cond = 8'h00;
    cyc();
    rst = 0; instr_valid = 0;
    chk("rst_resp_pc", int'(pc), 'h10);
    chk("rst_resp_retired", int'(retired), 0);
    chk("rst_resp_taken", int'(taken), 0);

    // Randomized per-cycle stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      halt        = ($urandom_range(0, 3) == 0);
      instr_valid = ($urandom_range(0, 9) < 7);
      instr       = $urandom_range(0, 1) ? (8'hC0 | 8'($urandom_range(0, 63))) : 8'($urandom);
      reg_target  = 8'($urandom);
      reg_cond    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cyc();
    end
    rst = 0; halt = 0; instr_valid = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
